// File: rtl/cla_adder.sv
// cla_adder -- registered two-level carry-lookahead adder.
//
// Computes {Cout,Sum} = A + B + Cin (unsigned, BITS+1 bits wide) through a
// combinational core built from 4-bit lookahead groups plus a second-level
// lookahead unit over the group generate/propagate terms.  The result is
// captured on each rising clk edge: one cycle of latency, one operand set
// accepted per cycle, no handshake.
//
// Parameters:
//   BITS     operand width; must be a multiple of 4 and at least 4.
// Ports:
//   clk      rising-edge clock for the output register
//   rst_n    asynchronous active-low reset; clears all outputs immediately
//   A, B     addends [BITS-1:0]
//   Cin      carry-in
//   Sum      registered sum [BITS-1:0]
//   Cout     registered carry-out of bit BITS-1
//   carries  registered per-bit carry-outs [BITS-1:0]
//            (only when CLA_CARRIES_EN is defined)
//
// Build option:
//   CLA_CARRIES_EN  adds the debug port `carries` and its register.

// One 4-bit lookahead group.  Produces the carries out of bits 0..2 directly
// from g/p and the group carry-in, plus the group generate/propagate terms.
// The carry out of bit 3 is not produced here: the second-level unit derives
// it from gg/gp, so every group boundary is resolved by lookahead.
module cla_group4 (
  input  logic [3:0] g,
  input  logic [3:0] p,
  input  logic       ci,
  output logic [2:0] co,
  output logic       gg,
  output logic       gp
);
  always_comb begin
    co[0] = g[0] | (p[0] & ci);
    co[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    co[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                 | (p[2] & p[1] & p[0] & ci);
    gg    = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                 | (p[3] & p[2] & p[1] & g[0]);
    gp    = &p;
  end
endmodule

module cla_adder #(
  parameter int BITS = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [BITS-1:0] A,
  input  logic [BITS-1:0] B,
  input  logic            Cin,
  output logic [BITS-1:0] Sum,
  output logic            Cout
`ifdef CLA_CARRIES_EN
  ,
  output logic [BITS-1:0] carries
`endif
);
  localparam int NG = BITS / 4;

  logic [BITS-1:0]      g, p;
  logic [NG-1:0][2:0]   co;      // in-group carries out of bits 0..2
  logic [NG-1:0]        gg, gp;
  logic [NG:0]          c_grp;   // c_grp[k] = carry into group k; c_grp[NG] = Cout
  logic [NG:0]          gin;     // {gg, Cin}: generate terms seen by level two
  logic [BITS-1:0]      c_out;   // carry out of each bit

  logic [BITS-1:0]      sum_d, sum_q;
  logic                 cout_d, cout_q;

  assign g = A & B;
  assign p = A ^ B;

  cla_group4 u_grp [NG-1:0] (
    .g  (g),
    .p  (p),
    .ci (c_grp[NG-1:0]),
    .co (co),
    .gg (gg),
    .gp (gp)
  );

  // Second-level lookahead as a flat sum of products:
  //   c_grp[k] = OR_{j=0..k} gin[j] & P[j] & ... & P[k-1]
  // with gin[0] = Cin and gin[j] = G[j-1]; the j == k term is just G[k-1].
  assign gin = {gg, Cin};

  always_comb begin
    logic prod;
    prod     = 1'b0;
    c_grp    = '0;
    c_grp[0] = Cin;
    for (int k = 1; k <= NG; k++) begin
      for (int j = 0; j <= k; j++) begin
        prod = gin[j];
        for (int m = j; m < k; m++) prod = prod & gp[m];
        c_grp[k] = c_grp[k] | prod;
      end
    end
  end

  // Bit 3 of each group takes its carry-out from the second-level unit.
  for (genvar i = 0; i < BITS; i++) begin : g_cout
    if (i % 4 == 3) begin : g_grp_msb
      assign c_out[i] = c_grp[i/4 + 1];
    end else begin : g_grp_bit
      assign c_out[i] = co[i/4][i%4];
    end
  end

  always_comb begin
    sum_d  = p ^ {c_out[BITS-2:0], Cin};
    cout_d = c_out[BITS-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end

  assign Sum  = sum_q;
  assign Cout = cout_q;

`ifdef CLA_CARRIES_EN
  logic [BITS-1:0] carries_d, carries_q;

  always_comb carries_d = c_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) carries_q <= '0;
    else        carries_q <= carries_d;
  end

  assign carries = carries_q;
`endif

endmodule

// File: tb/tb_cla_adder.sv
// Directed + random self-checking bench for cla_adder at BITS = 8, 4, 16.
module tb_cla_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  a8 = '0, b8 = '0, s8;
  logic        ci8 = 1'b0, co8;
  logic [3:0]  a4 = '0, b4 = '0, s4;
  logic        ci4 = 1'b0, co4;
  logic [15:0] a16 = '0, b16 = '0, s16;
  logic        ci16 = 1'b0, co16;
`ifdef CLA_CARRIES_EN
  logic [7:0]  cr8;
  logic [3:0]  cr4;
  logic [15:0] cr16;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  cla_adder #(.BITS(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .A(a8), .B(b8), .Cin(ci8), .Sum(s8), .Cout(co8)
`ifdef CLA_CARRIES_EN
    , .carries(cr8)
`endif
  );

  cla_adder #(.BITS(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .A(a4), .B(b4), .Cin(ci4), .Sum(s4), .Cout(co4)
`ifdef CLA_CARRIES_EN
    , .carries(cr4)
`endif
  );

  cla_adder #(.BITS(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .A(a16), .B(b16), .Cin(ci16), .Sum(s16), .Cout(co16)
`ifdef CLA_CARRIES_EN
    , .carries(cr16)
`endif
  );

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    a8 = 8'hFF; b8 = 8'hFF; ci8 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({co8, s8} !== 9'h000) begin
      n_fail++; $display("FAIL reset8: got %h exp 000", {co8, s8});
    end
    n_tests++;
    if ({co4, s4, co16, s16} !== 22'h0) begin
      n_fail++; $display("FAIL reset4_16: got %h/%h exp 0", {co4, s4}, {co16, s16});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if ({co8, s8} !== 9'h1FF) begin
      n_fail++; $display("FAIL reset_release: got %h exp 1ff", {co8, s8});
    end
  endtask

  task automatic test_overflow();
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'h01; ci8 = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if ({co8, s8} !== 9'h100) begin
      n_fail++; $display("FAIL overflow: got %h exp 100", {co8, s8});
    end
`ifdef CLA_CARRIES_EN
    n_tests++;
    if (cr8 !== 8'hFF) begin
      n_fail++; $display("FAIL overflow_carries: got %h exp ff", cr8);
    end
`endif
  endtask

  task automatic test_boundary();
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF; ci8 = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if ({co8, s8} !== 9'h1FF) begin
      n_fail++; $display("FAIL ones_ones_cin: got %h exp 1ff", {co8, s8});
    end
    @(negedge clk);
    a8 = 8'h00; b8 = 8'h00; ci8 = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if ({co8, s8} !== 9'h000) begin
      n_fail++; $display("FAIL zeros: got %h exp 000", {co8, s8});
    end
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'h00; ci8 = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if ({co8, s8} !== 9'h100) begin
      n_fail++; $display("FAIL ones_plus_cin: got %h exp 100", {co8, s8});
    end
  endtask

  // Operands change every edge; each result checked one cycle later.
  task automatic test_back_to_back();
    logic [7:0] va [3] = '{8'hAC, 8'hBD, 8'hEF};
    logic [7:0] vb [3] = '{8'h47, 8'h38, 8'h27};
    logic       vc [3] = '{1'b0, 1'b1, 1'b1};
    logic [8:0] ve [3] = '{9'h0F3, 9'h0F6, 9'h117};
    @(negedge clk);
    a8 = va[0]; b8 = vb[0]; ci8 = vc[0];
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_tests++;
      if ({co8, s8} !== ve[i]) begin
        n_fail++; $display("FAIL b2b[%0d]: got %h exp %h", i, {co8, s8}, ve[i]);
      end
      if (i < 2) begin
        a8 = va[i+1]; b8 = vb[i+1]; ci8 = vc[i+1];
      end
    end
  endtask

  task automatic test_bits4();
    logic [3:0] va [4] = '{4'hF, 4'hA, 4'h4, 4'h9};
    logic [3:0] vb [4] = '{4'h1, 4'h4, 4'h7, 4'hC};
    logic       vc [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [4:0] ve [4] = '{5'h10, 5'h0E, 5'h0C, 5'h15};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a4 = va[i]; b4 = vb[i]; ci4 = vc[i];
      @(posedge clk); #1;
      n_tests++;
      if ({co4, s4} !== ve[i]) begin
        n_fail++; $display("FAIL bits4[%0d]: got %h exp %h", i, {co4, s4}, ve[i]);
      end
    end
  endtask

  // Inputs moving between edges must not reach the outputs before the next edge.
  task automatic test_hold();
    @(negedge clk);
    a8 = 8'h12; b8 = 8'h34; ci8 = 1'b0;
    @(posedge clk); #1;
    a8 = 8'hF0; b8 = 8'hF0; ci8 = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({co8, s8} !== 9'h046) begin
      n_fail++; $display("FAIL hold: got %h exp 046", {co8, s8});
    end
    @(posedge clk); #1;
    n_tests++;
    if ({co8, s8} !== 9'h1E1) begin
      n_fail++; $display("FAIL hold_next: got %h exp 1e1", {co8, s8});
    end
  endtask

  task automatic test_random();
    logic [16:0] exp;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      a16  = 16'($urandom_range(0, 65535));
      b16  = 16'($urandom_range(0, 65535));
      ci16 = 1'($urandom_range(0, 1));
      exp  = {1'b0, a16} + {1'b0, b16} + {16'h0, ci16};
      @(posedge clk); #1;
      n_tests++;
      if ({co16, s16} !== exp) begin
        n_fail++;
        $display("FAIL random[%0d]: %h+%h+%b got %h exp %h", i, a16, b16, ci16, {co16, s16}, exp);
      end
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    a8 = 8'h80; b8 = 8'h81; ci8 = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if ({co8, s8} !== 9'h101) begin
      n_fail++; $display("FAIL pre_reset: got %h exp 101", {co8, s8});
    end
    #1 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({co8, s8} !== 9'h000) begin
      n_fail++; $display("FAIL async_clear: got %h exp 000", {co8, s8});
    end
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({co8, s8} !== 9'h000) begin
      n_fail++; $display("FAIL reset_hold: got %h exp 000", {co8, s8});
    end
    @(negedge clk);
    a8 = 8'h05; b8 = 8'h03; ci8 = 1'b1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if ({co8, s8} !== 9'h009) begin
      n_fail++; $display("FAIL post_reset: got %h exp 009", {co8, s8});
    end
  endtask

  initial begin
    test_reset();
    test_overflow();
    test_boundary();
    test_back_to_back();
    test_bits4();
    test_hold();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/cla_adder.md
CLA_ADDER -- requirements
Module: cla_adder

Interface
REQ-001 Parameter BITS, default 8, operand width; SHALL be a multiple of 4 and at least 4.
REQ-002 Port clk  input  1  rising-edge clock for the output register.
REQ-003 Port rst_n  input  1  asynchronous active-low reset.
REQ-004 Port A  input  BITS  addend A.
REQ-005 Port B  input  BITS  addend B.
REQ-006 Port Cin  input  1  carry-in.
REQ-007 Port Sum  output  BITS  registered sum.
REQ-008 Port Cout  output  1  registered carry-out.
REQ-009 Port carries  output  BITS  registered per-bit carry-outs; present only per REQ-024.

Function
REQ-010 The block SHALL compute {Cout,Sum} = A + B + Cin, unsigned, modulo 2^(BITS+1), with no truncation or saturation.
REQ-011 Bit level SHALL form generate g[i]=A[i]&B[i] and propagate p[i]=A[i]^B[i]; sum bit Sum[i]=p[i]^c[i], where c[0]=Cin.
REQ-012 Carries SHALL use two-level lookahead, with no ripple chain across bits:
- 4-bit groups compute in-group carries directly from g, p and the group carry-in.
- Each group exports group generate G and group propagate P.
- A second-level lookahead unit computes every group carry-in from Cin, G and P.
REQ-013 Cout SHALL equal the carry out of bit BITS-1.
REQ-014 The adder core SHALL be combinational; Sum, Cout (and carries) SHALL be captured in registers on each rising clk edge.
REQ-015 Latency:
- Exactly 1 cycle, with a new operand set accepted every cycle (throughput 1/cycle).
- Values sampled at edge n appear on the outputs after edge n.
- No handshake signals.
REQ-016 Boundary cases:
- All-ones + 1 SHALL wrap Sum to 0 with Cout=1.
- All-ones + all-ones + Cin=1 SHALL give Sum all-ones, Cout=1.
- 0 + 0 + 0 SHALL give 0, Cout=0.
REQ-017 Inputs changing between edges SHALL NOT affect outputs until the next edge.

Reset
REQ-018 rst_n low SHALL immediately, without a clock edge, force Sum=0, Cout=0 and carries=0.
REQ-019 While rst_n is low, outputs SHALL hold zero regardless of clk and inputs.
REQ-020 Reset deassertion SHALL be synchronized externally; the first capture SHALL occur on the first rising clk edge with rst_n high.
REQ-021 Assertion of reset mid-stream SHALL discard the pending result; no result from before reset SHALL appear after it.

Configuration
REQ-022 Macro CLA_CARRIES_EN controls the debug carry port.
REQ-023 Without CLA_CARRIES_EN defined, port carries and its register SHALL NOT exist; other behaviour SHALL be unchanged.
REQ-024 With CLA_CARRIES_EN defined, carries[i] SHALL be the registered carry out of bit i (so carries[BITS-1]==Cout), with the same latency and reset as Sum.

Verification
REQ-025 Reset: rst_n=0 with A=FF, B=FF, Cin=1 and clk running -> Sum=00, Cout=0; after release and one edge -> Sum=FF, Cout=1.
REQ-026 BITS=8, Cin=0, A=FF, B=01 -> one edge later Sum=00, Cout=1 (overflow wrap); with CLA_CARRIES_EN, carries=FF.
REQ-027 BITS=8, back-to-back on consecutive edges, each result one cycle after its operands:
- Cin=0, A=AC, B=47 -> Sum=F3, Cout=0.
- Cin=1, A=BD, B=38 -> Sum=F6, Cout=0.
- Cin=1, A=EF, B=27 -> Sum=17, Cout=1.
REQ-028 BITS=4:
- Cin=0, A=F, B=1 -> Sum=0, Cout=1.
- Cin=0, A=A, B=4 -> Sum=E, Cout=0.
- Cin=1, A=4, B=7 -> Sum=C, Cout=0.
- Cin=0, A=9, B=C -> Sum=5, Cout=1.
REQ-029 Random: BITS=16, 10000 random operand sets -> every registered result matches the A+B+Cin reference model one cycle later.
REQ-030 Async reset mid-stream: assert rst_n low between edges -> outputs go to 0 before the next edge and stay 0 until release.
